// File: rtl/trigger_gate_pkg.sv
// Shared types and defaults for the trigger acceptance stage.
// Used by trigger_gate and sync_edge.
package trigger_gate_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      DEAD   = 2'd2
   } state_e;

   localparam int unsigned TS_W_DEF  = 32;
   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned DT_W_DEF  = 8;

   // Floor on the dead countdown: covers the trig -> busy round trip in busy_control.
   localparam int unsigned DT_MIN    = 2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus a third flop
// used for rising-edge detection in the clk domain.
module sync_edge
   import trigger_gate_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/trigger_gate.sv
// Trigger acceptance: synchronise raw trigger, gate on live/busy/dead time,
// timestamp accepts. Monitoring counters built only with TRIGGER_GATE_VETO_CNT_EN.
module trigger_gate
   import trigger_gate_pkg::*;
#(
   parameter int unsigned TS_W  = TS_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned DT_W  = DT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             live,
   input  logic             live_rising,
   input  logic             trig_in,
   input  logic             busy,
   input  logic [DT_W-1:0]  dead_time,
   output logic             trig,
   output logic [TS_W-1:0]  trig_timestamp,
   output logic [CNT_W-1:0] n_raw,
   output logic [CNT_W-1:0] n_veto_busy,
   output logic [CNT_W-1:0] n_veto_dead
);

   localparam logic [DT_W-1:0] DT_FLOOR = DT_W'(DT_MIN);

   state_e           state_q, state_d;
   logic [DT_W-1:0]  dcnt_q, dcnt_d;
   logic             trig_q;
   logic [TS_W-1:0]  ts_q;
   logic [TS_W-1:0]  tstamp_q;
   logic             raw_edge;
   logic             accept;

   sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (trig_in),
      .rise_o (raw_edge)
   );

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (raw_edge && live && !busy) begin
               state_d = ACCEPT;
               accept  = 1'b1;
            end
         end
         ACCEPT: begin
            dcnt_d  = (dead_time < DT_FLOOR) ? DT_FLOOR : dead_time;
            state_d = DEAD;
         end
         DEAD: begin
            dcnt_d = dcnt_q - DT_W'(1);
            if (dcnt_q <= DT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Run start overrides whatever the FSM was about to do.
      if (live_rising) begin
         state_d = IDLE;
         dcnt_d  = '0;
         accept  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         dcnt_q   <= '0;
         trig_q   <= 1'b0;
         ts_q     <= '0;
         tstamp_q <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         trig_q  <= accept;
         if (live_rising) begin
            ts_q     <= '0;
            tstamp_q <= '0;
         end else begin
            ts_q <= ts_q + TS_W'(1);
            if (accept) begin
               tstamp_q <= ts_q;
            end
         end
      end
   end

   assign trig           = trig_q;
   assign trig_timestamp = tstamp_q;

`ifdef TRIGGER_GATE_VETO_CNT_EN
   logic [CNT_W-1:0] n_raw_q, n_vbusy_q, n_vdead_q;
   logic             cnt_raw, cnt_dead, cnt_busy;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && !(&v)) ? v + CNT_W'(1) : v;
   endfunction

   // Dead-time veto takes priority, so an edge lands in at most one veto counter.
   always_comb begin
      cnt_raw  = raw_edge & live;
      cnt_dead = cnt_raw & ((state_q == ACCEPT) || (state_q == DEAD));
      cnt_busy = cnt_raw & (state_q == IDLE) & busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_raw_q   <= '0;
         n_vbusy_q <= '0;
         n_vdead_q <= '0;
      end else if (live_rising) begin
         n_raw_q   <= '0;
         n_vbusy_q <= '0;
         n_vdead_q <= '0;
      end else begin
         n_raw_q   <= sat_inc(n_raw_q, cnt_raw);
         n_vbusy_q <= sat_inc(n_vbusy_q, cnt_busy);
         n_vdead_q <= sat_inc(n_vdead_q, cnt_dead);
      end
   end

   assign n_raw       = n_raw_q;
   assign n_veto_busy = n_vbusy_q;
   assign n_veto_dead = n_vdead_q;
`else
   assign n_raw       = '0;
   assign n_veto_busy = '0;
   assign n_veto_dead = '0;
`endif

endmodule

// File: tb/tb_trigger_gate.sv
// Self-checking bench for trigger_gate: directed scenarios then random traffic,
// compared each cycle against a cycle-window reference model.
module tb_trigger_gate;

   localparam int unsigned TS_W  = 32;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DT_W  = 8;
   localparam int unsigned CMAX  = (1 << CNT_W) - 1;
`ifdef TRIGGER_GATE_VETO_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, live, live_rising, trig_in, busy;
   logic [DT_W-1:0]  dead_time;
   logic             trig;
   logic [TS_W-1:0]  trig_timestamp;
   logic [CNT_W-1:0] n_raw, n_veto_busy, n_veto_dead;

   trigger_gate #(.TS_W(TS_W), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .live           (live),
      .live_rising    (live_rising),
      .trig_in        (trig_in),
      .busy           (busy),
      .dead_time      (dead_time),
      .trig           (trig),
      .trig_timestamp (trig_timestamp),
      .n_raw          (n_raw),
      .n_veto_busy    (n_veto_busy),
      .n_veto_dead    (n_veto_dead)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference model: edges are judged against the window of clock edges
   // following the last accept, rather than an explicit state machine.
   int unsigned     cyc = 0;
   bit              hist [3];
   bit              have_acc;
   int unsigned     acc_e, acc_k;
   logic [TS_W-1:0] m_ts, m_tstamp;
   bit              m_trig;
   int unsigned     m_raw, m_vb, m_vd;

   function automatic int unsigned expc(input int unsigned v);
      if (!CNT_EN) return 0;
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("trig", 64'(trig), 64'(m_trig));
      chk("trig_timestamp", 64'(trig_timestamp), 64'(m_tstamp));
      chk("n_raw", 64'(n_raw), 64'(expc(m_raw)));
      chk("n_veto_busy", 64'(n_veto_busy), 64'(expc(m_vb)));
      chk("n_veto_dead", 64'(n_veto_dead), 64'(expc(m_vd)));
   endtask

   task automatic model_reset();
      hist     = '{0, 0, 0};
      have_acc = 0;
      m_ts     = '0;
      m_tstamp = '0;
      m_trig   = 0;
      m_raw    = 0;
      m_vb     = 0;
      m_vd     = 0;
   endtask

   // Evaluate the model for the coming clock edge with the inputs now applied.
   task automatic model_edge();
      bit raw, dead;
      raw  = hist[1] && !hist[2];
      dead = have_acc && (cyc >= acc_e + 1) && (cyc <= acc_e + acc_k + 1);
      if (have_acc && cyc == acc_e + 1) acc_k = (dead_time < 2) ? 2 : int'(dead_time);
      m_trig = 0;
      if (live_rising) begin
         have_acc = 0;
         m_ts     = '0;
         m_tstamp = '0;
         m_raw    = 0;
         m_vb     = 0;
         m_vd     = 0;
      end else begin
         if (raw && live) begin
            m_raw++;
            if (dead) m_vd++;
            else if (busy) m_vb++;
            else begin
               m_trig   = 1;
               m_tstamp = m_ts;
               have_acc = 1;
               acc_e    = cyc;
               acc_k    = 100000;
            end
         end
         m_ts = m_ts + 1;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = trig_in;
      cyc++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input int unsigned hi, input int unsigned lo);
      trig_in = 1'b1;
      idle(hi);
      trig_in = 1'b0;
      idle(lo);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 1'b1; live = 1'b0; live_rising = 1'b0; trig_in = 1'b0;
      busy = 1'b0; dead_time = 8'd10;
      model_reset();
      #12;
      check_all();
      rst = 1'b0;

      // Run start
      live = 1'b1; live_rising = 1'b1;
      tick();
      live_rising = 1'b0;
      idle(3);

      // Single trigger: latency of three edges
      seen = 0;
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         tick();
         if (trig === 1'b1 && seen == 0) seen = i;
      end
      chk("latency", 64'(seen), 64'd3);
      idle(15);

      // Second edge 5 cycles later falls in dead time
      pulse(1, 4);
      pulse(1, 25);

      // Busy vetoes
      busy = 1'b1;
      for (int i = 0; i < 4; i++) pulse(2, 18);
      busy = 1'b0;
      idle(5);

      // Minimum dead time floor with edges every 4 cycles
      dead_time = 8'd0;
      for (int i = 0; i < 6; i++) pulse(1, 3);
      idle(6);

      // Edges while not live, then run start coincident with an edge
      live = 1'b0;
      for (int i = 0; i < 3; i++) pulse(1, 5);
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      tick();
      live = 1'b1; live_rising = 1'b1;
      tick();
      live_rising = 1'b0;
      chk("lr_no_trig", 64'(trig), 64'd0);
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      idle(2);
      chk("ts_restart", 64'(trig_timestamp), 64'd2);
      idle(6);

      // Saturation of counters
      busy = 1'b1;
      for (int i = 0; i < CMAX + 3; i++) pulse(1, 3);
      busy = 1'b0;
      idle(4);

      // Held-high input gives one edge; dead_time changed mid-countdown
      dead_time = 8'd20;
      pulse(12, 3);
      dead_time = 8'd3;
      for (int i = 0; i < 8; i++) pulse(1, 3);
      idle(6);

      // Reset in the middle of dead time
      dead_time = 8'd50;
      pulse(1, 6);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      pulse(1, 8);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         trig_in     = ($urandom_range(0, 2) == 0);
         busy        = ($urandom_range(0, 3) == 0);
         live_rising = 1'b0;
         if ($urandom_range(0, 99) == 0) live = ~live;
         if ($urandom_range(0, 199) == 0) begin
            live = 1'b1;
            live_rising = 1'b1;
         end
         if ($urandom_range(0, 29) == 0) dead_time = DT_W'($urandom_range(0, 12));
         tick();
      end
      live_rising = 1'b0;
      trig_in = 1'b0;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
